snapreg_mb: RTL and testbench

- Multi-bank, parametrised snapshot register file for the DRCP extension datapath.
- Holds NBANK banks of NREG x XLEN registers; register 0 of every bank reads as zero.
- Supports batch write, batch read, bank clear and a multi-cycle bank-to-bank copy engine behind a req/ack handshake.
- Sits beside the custom-instruction decoder, which drives funct7, bank and batch fields and the rs operand vector.

---
 rtl/snapreg_mb_if.sv | 35 +++
 rtl/snapreg_mb.sv | 148 ++++++++++++++
 tb/tb_snapreg_mb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/snapreg_mb_if.sv
// Request/response bundle between the custom-instruction decoder and snapreg_mb.
interface snapreg_mb_if #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NBANK  = 4,
  parameter int RS_MAX = 8,
  parameter int RD_MAX = 8
);
  localparam int IDX_W  = $clog2(NREG);
  localparam int BANK_W = $clog2(NBANK);

  logic                           sreg_req;
  logic [6:0]                     sreg_funct7;
  logic [BANK_W-1:0]              sreg_bank;
  logic [BANK_W-1:0]              sreg_dst_bank;
  logic [IDX_W-1:0]               sreg_batch_start;
  logic [IDX_W:0]                 sreg_batch_len;
  logic [RS_MAX-1:0][XLEN-1:0]    sreg_rs_val;
  logic                           sreg_ack;
  logic                           sreg_error;
  logic                           sreg_busy;
  logic [RD_MAX-1:0][XLEN-1:0]    sreg_rd_val;

  modport master (
    output sreg_req, sreg_funct7, sreg_bank, sreg_dst_bank,
           sreg_batch_start, sreg_batch_len, sreg_rs_val,
    input  sreg_ack, sreg_error, sreg_busy, sreg_rd_val
  );

  modport slave (
    input  sreg_req, sreg_funct7, sreg_bank, sreg_dst_bank,
           sreg_batch_start, sreg_batch_len, sreg_rs_val,
    output sreg_ack, sreg_error, sreg_busy, sreg_rd_val
  );
endinterface

// File: rtl/snapreg_mb.sv
// Multi-bank snapshot register file: batch write/read, bank clear, bank-to-bank copy.
// SNAPREG_MB_COPY_EN enables the multi-cycle copy engine; otherwise copy requests error out.
module snapreg_mb #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int NBANK      = 4,
  parameter int RS_MAX     = 8,
  parameter int RD_MAX     = 8,
  parameter int COPY_LANES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  snapreg_mb_if.slave sreg
);
  localparam int IDX_W  = $clog2(NREG);
  localparam int BANK_W = $clog2(NBANK);

`ifdef SNAPREG_MB_COPY_EN
  localparam int NCOPY = NREG / COPY_LANES;
  localparam int CNT_W = $clog2(NCOPY) + 1;
  typedef enum logic [1:0] {IDLE, RESP, COPY} state_e;
`else
  typedef enum logic [1:0] {IDLE, RESP} state_e;
`endif

  state_e state_q, state_d;
  logic [NBANK-1:0][NREG-1:0][XLEN-1:0] mem;
  logic [RD_MAX-1:0][XLEN-1:0]          rd_val_q;
  logic                                 err_q;

  logic is_wr, is_rd, is_cp, is_clr, bank_bad, range_bad, req_err, accept, do_copy;
  logic [IDX_W+1:0] end_idx;
  logic [RS_MAX-1:0][IDX_W-1:0] wr_idx;
  logic [RS_MAX-1:0]            wr_lane;
  logic [RD_MAX-1:0][IDX_W-1:0] rd_idx;
  logic [RD_MAX-1:0]            rd_lane;

  for (genvar k = 0; k < RS_MAX; k++) begin : g_wr
    assign wr_idx[k]  = sreg.sreg_batch_start + IDX_W'(k);
    assign wr_lane[k] = (IDX_W+2)'(k) < {1'b0, sreg.sreg_batch_len};
  end

  for (genvar k = 0; k < RD_MAX; k++) begin : g_rd
    assign rd_idx[k]  = sreg.sreg_batch_start + IDX_W'(k);
    assign rd_lane[k] = (IDX_W+2)'(k) < {1'b0, sreg.sreg_batch_len};
  end

`ifdef SNAPREG_MB_COPY_EN
  logic [CNT_W-1:0]  cnt_q;
  logic [BANK_W-1:0] src_q, dst_q;
  logic              dst_bad;
  logic [COPY_LANES-1:0][IDX_W-1:0] cp_idx;

  for (genvar j = 0; j < COPY_LANES; j++) begin : g_cp
    assign cp_idx[j] = IDX_W'(int'(cnt_q) * COPY_LANES + j);
  end
`endif

  always_comb begin
    is_wr     = sreg.sreg_funct7 == 7'b0000000;
    is_rd     = sreg.sreg_funct7 == 7'b1000000;
    is_cp     = sreg.sreg_funct7 == 7'b0100000;
    is_clr    = sreg.sreg_funct7 == 7'b0010000;
    end_idx   = (IDX_W+2)'(sreg.sreg_batch_start) + (IDX_W+2)'(sreg.sreg_batch_len);
    range_bad = end_idx > (IDX_W+2)'(NREG);
    bank_bad  = {1'b0, sreg.sreg_bank} >= (BANK_W+1)'(NBANK);
    req_err   = 1'b1;
    do_copy   = 1'b0;
`ifdef SNAPREG_MB_COPY_EN
    dst_bad   = {1'b0, sreg.sreg_dst_bank} >= (BANK_W+1)'(NBANK);
`endif
    // start/len only matter to batch ops, so clear and copy ignore the range check
    if (is_wr)       req_err = bank_bad || range_bad || (sreg.sreg_batch_len > (IDX_W+1)'(RS_MAX));
    else if (is_rd)  req_err = bank_bad || range_bad || (sreg.sreg_batch_len > (IDX_W+1)'(RD_MAX));
    else if (is_clr) req_err = bank_bad;
`ifdef SNAPREG_MB_COPY_EN
    else if (is_cp) begin
      req_err = bank_bad || dst_bad;
      do_copy = !req_err && (sreg.sreg_bank != sreg.sreg_dst_bank);
    end
`endif
    accept = (state_q == IDLE) && sreg.sreg_req;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = do_copy ? state_e'(2) : RESP;
      RESP: state_d = IDLE;
`ifdef SNAPREG_MB_COPY_EN
      COPY: if (cnt_q == CNT_W'(NCOPY - 1)) state_d = RESP;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem      <= '0;
      rd_val_q <= '0;
      err_q    <= 1'b0;
`ifdef SNAPREG_MB_COPY_EN
      cnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
`endif
    end else begin
      if (accept) begin
        err_q <= req_err;
        if (!req_err && is_wr) begin
          // index 0 is never written so it keeps reading as zero
          for (int k = 0; k < RS_MAX; k++)
            if (wr_lane[k] && wr_idx[k] != '0)
              mem[sreg.sreg_bank][wr_idx[k]] <= sreg.sreg_rs_val[k];
        end
        if (!req_err && is_rd) begin
          for (int k = 0; k < RD_MAX; k++)
            rd_val_q[k] <= rd_lane[k] ? mem[sreg.sreg_bank][rd_idx[k]] : '0;
        end
        if (!req_err && is_clr) mem[sreg.sreg_bank] <= '0;
`ifdef SNAPREG_MB_COPY_EN
        if (do_copy) begin
          src_q <= sreg.sreg_bank;
          dst_q <= sreg.sreg_dst_bank;
          cnt_q <= '0;
        end
`endif
      end
`ifdef SNAPREG_MB_COPY_EN
      if (state_q == COPY) begin
        for (int j = 0; j < COPY_LANES; j++)
          if (cp_idx[j] != '0) mem[dst_q][cp_idx[j]] <= mem[src_q][cp_idx[j]];
        cnt_q <= cnt_q + 1'b1;
      end
`endif
    end
  end

  assign sreg.sreg_ack    = state_q == RESP;
  assign sreg.sreg_error  = (state_q == RESP) && err_q;
  assign sreg.sreg_busy   = state_q != IDLE;
  assign sreg.sreg_rd_val = rd_val_q;
endmodule

// File: tb/tb_snapreg_mb.sv
// Scoreboard bench for snapreg_mb: driver queues expected responses, negedge monitor checks them.
module tb_snapreg_mb;
  typedef logic [7:0][31:0] vec_t;
  typedef struct {
    bit   err;
    bit   chk_rd;
    vec_t rd;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  snapreg_mb_if #(.XLEN(32), .NREG(32), .NBANK(4), .RS_MAX(8), .RD_MAX(8)) sif ();

  snapreg_mb #(.XLEN(32), .NREG(32), .NBANK(4), .RS_MAX(8), .RD_MAX(8), .COPY_LANES(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sreg  (sif)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks accept/ack timing and busy width, pops expectations on ack.
  initial begin
    int ncyc, acc_cyc, busy_cnt;
    exp_t e;
    ncyc = 0; acc_cyc = 0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_n) begin
        if (sif.sreg_busy) busy_cnt++;
        if (sif.sreg_req && !sif.sreg_busy) begin
          acc_cyc  = ncyc;
          busy_cnt = 0;
        end
        if (!sif.sreg_ack && sif.sreg_error) begin
          failures++;
          $display("FAIL error_without_ack actual=1 expected=0");
        end
        if (sif.sreg_ack) begin
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack actual=1 expected=0");
          end else begin
            e = q.pop_front();
            chk("error", 256'(sif.sreg_error), 256'(e.err));
            chk("latency", 256'(ncyc - acc_cyc), 256'(e.lat));
            chk("busy_cycles", 256'(busy_cnt), 256'(e.lat));
            if (e.chk_rd) chk("rd_val", sif.sreg_rd_val, e.rd);
          end
        end
      end
    end
  end

  task automatic issue(input logic [6:0] f7, input int bank, input int dst, input int start,
                       input int len, input vec_t rs, input bit err, input bit chk_rd,
                       input vec_t rd, input int lat);
    exp_t e;
    bit   got;
    e.err = err; e.chk_rd = chk_rd; e.rd = rd; e.lat = lat;
    q.push_back(e);
    @(posedge clk); #1;
    sif.sreg_funct7      = f7;
    sif.sreg_bank        = 2'(bank);
    sif.sreg_dst_bank    = 2'(dst);
    sif.sreg_batch_start = 5'(start);
    sif.sreg_batch_len   = 6'(len);
    sif.sreg_rs_val      = rs;
    sif.sreg_req         = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (sif.sreg_ack) got = 1'b1;
    end
    #1 sif.sreg_req = 1'b0;
    if (!got) begin
      failures++;
      $display("FAIL ack_timeout actual=none expected=ack f7=%b", f7);
      q.delete();
    end
  endtask

  task automatic wr(input int bank, input int start, input int len, input vec_t rs);
    issue(7'b0000000, bank, 0, start, len, rs, 1'b0, 1'b0, '0, 1);
  endtask

  task automatic rd(input int bank, input int start, input int len, input vec_t exp);
    issue(7'b1000000, bank, 0, start, len, '0, 1'b0, 1'b1, exp, 1);
  endtask

  task automatic rd_err(input logic [6:0] f7, input int bank, input int start, input int len);
    issue(f7, bank, 0, start, len, '0, 1'b1, 1'b0, '0, 1);
  endtask

  initial begin
    vec_t v, e;
    int   lat_cp;
    bit   err_cp;
`ifdef SNAPREG_MB_COPY_EN
    lat_cp = 9; err_cp = 1'b0;
`else
    lat_cp = 1; err_cp = 1'b1;
`endif
    sif.sreg_req = 1'b0; sif.sreg_funct7 = '0; sif.sreg_bank = '0; sif.sreg_dst_bank = '0;
    sif.sreg_batch_start = '0; sif.sreg_batch_len = '0; sif.sreg_rs_val = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", 256'(sif.sreg_ack), 256'(0));
    chk("reset_busy", 256'(sif.sreg_busy), 256'(0));
    chk("reset_error", 256'(sif.sreg_error), 256'(0));
    chk("reset_rd_val", sif.sreg_rd_val, 256'(0));
    #1 rst_n = 1'b1;

    rd(0, 0, 8, '0);

    v = '0; v[0] = 32'hA0; v[1] = 32'hA1; v[2] = 32'hA2; v[3] = 32'hA3;
    wr(1, 3, 4, v);
    e = '0; e[1] = 32'hA0; e[2] = 32'hA1; e[3] = 32'hA2; e[4] = 32'hA3;
    rd(1, 2, 6, e);
    rd(0, 0, 8, '0);

    v = '0; v[0] = 32'hFFFF; v[1] = 32'h1234;
    wr(2, 0, 2, v);
    e = '0; e[1] = 32'h1234;
    rd(2, 0, 2, e);

    v = '0; v[0] = 32'hB0; v[1] = 32'hB1; v[2] = 32'hB2; v[3] = 32'hB3;
    wr(1, 28, 4, v);
    v = '0; v[0] = 32'hC0; v[1] = 32'hC1; v[2] = 32'hC2; v[3] = 32'hC3;
    issue(7'b0000000, 1, 0, 30, 4, v, 1'b1, 1'b0, '0, 1);
    e = '0; e[0] = 32'hB0; e[1] = 32'hB1; e[2] = 32'hB2; e[3] = 32'hB3;
    rd(1, 28, 4, e);
    rd_err(7'b1000000, 0, 0, 9);
    rd_err(7'b0000001, 0, 0, 1);

    issue(7'b0010000, 1, 0, 0, 0, '0, 1'b0, 1'b0, '0, 1);
    rd(1, 0, 8, '0);
    rd(1, 24, 8, '0);

    v = '1;
    wr(2, 5, 0, v);
    e = '0; e[1] = 32'h1234;
    rd(2, 0, 8, e);
    rd(2, 0, 0, '0);

    for (int c = 0; c < 4; c++) begin
      v = '0;
      for (int k = 0; k < 8; k++) v[k] = 32'((c*8 + k) * 32'h11);
      wr(0, c*8, 8, v);
    end
    issue(7'b0100000, 0, 3, 0, 0, '0, err_cp, 1'b0, '0, lat_cp);
    for (int c = 0; c < 4; c++) begin
      e = '0;
      for (int k = 0; k < 8; k++) e[k] = 32'((c*8 + k) * 32'h11);
      rd(0, c*8, 8, e);
`ifndef SNAPREG_MB_COPY_EN
      e = '0;
`endif
      rd(3, c*8, 8, e);
    end
    issue(7'b0100000, 2, 2, 0, 0, '0, err_cp, 1'b0, '0, 1);

`ifdef SNAPREG_MB_COPY_EN
    @(posedge clk); #1;
    sif.sreg_funct7 = 7'b0100000; sif.sreg_bank = 2'd0; sif.sreg_dst_bank = 2'd1;
    sif.sreg_req = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; sif.sreg_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ack", 256'(sif.sreg_ack), 256'(0));
    chk("abort_busy", 256'(sif.sreg_busy), 256'(0));
    #1 rst_n = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 4; c++) rd(b, c*8, 8, '0);
`endif

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
